// File: rtl/dct_coeff_accum_if.sv
// rtl/dct_coeff_accum_if.sv - pixel stream, cosine LUT and coefficient stream bundle for dct_coeff_accum
interface dct_coeff_accum_if #(
    parameter int OUT_W = 16
) ();
    logic                    pix_valid;
    logic                    pix_ready;
    logic        [7:0]       pix_data;
    logic        [2:0]       lut_n1;
    logic        [2:0]       lut_n2;
    logic signed [31:0]      lut_cos;
    logic                    coef_valid;
    logic                    coef_ready;
    logic signed [OUT_W-1:0] coef_data;

    modport master (
        output pix_valid, pix_data, lut_cos, coef_ready,
        input  pix_ready, lut_n1, lut_n2, coef_valid, coef_data
    );

    modport slave (
        input  pix_valid, pix_data, lut_cos, coef_ready,
        output pix_ready, lut_n1, lut_n2, coef_valid, coef_data
    );
endinterface

// File: rtl/dct_coeff_accum.sv
// rtl/dct_coeff_accum.sv - accumulates one 8x8 2-D DCT coefficient from a pixel stream and a cosine LUT
module dct_coeff_accum #(
    parameter int ACC_W     = 48,
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    dct_coeff_accum_if.slave  bus
);
    localparam int PROD_W = 9 + 32;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t                  state;
    logic        [2:0]       n1;
    logic        [2:0]       n2;
    logic signed [ACC_W-1:0] acc;
    logic                    pix_ready_q;
    logic                    coef_valid_q;
    logic signed [OUT_W-1:0] coef_data_q;

    logic                    pix_fire;
    logic                    coef_fire;
    logic signed [8:0]       d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] shifted;
    logic signed [OUT_W-1:0] sat_value;

    assign bus.lut_n1     = n1;
    assign bus.lut_n2     = n2;
    assign bus.pix_ready  = pix_ready_q;
    assign bus.coef_valid = coef_valid_q;
    assign bus.coef_data  = coef_data_q;

    assign pix_fire  = bus.pix_valid & pix_ready_q;
    assign coef_fire = coef_valid_q & bus.coef_ready;

    // Level shift to a signed 9-bit sample; the LUT answers for the registered address this cycle.
    assign d        = $signed({1'b0, bus.pix_data}) - 9'sd128;
    assign prod     = d * bus.lut_cos;
    assign acc_next = acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign shifted  = acc_next >>> FRAC_BITS;

    always_comb begin
        sat_value = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_value = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_value = SAT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            n1           <= 3'd0;
            n2           <= 3'd0;
            acc          <= '0;
            pix_ready_q  <= 1'b1;
            coef_valid_q <= 1'b0;
            coef_data_q  <= '0;
        end else if (flush) begin
            state        <= ACCUM;
            n1           <= 3'd0;
            n2           <= 3'd0;
            acc          <= '0;
            pix_ready_q  <= 1'b1;
            coef_valid_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (pix_fire) begin
                        acc <= acc_next;
                        if (n2 == 3'd7) begin
                            n2 <= 3'd0;
                            if (n1 == 3'd7) begin
                                // Last pixel of the block: the coefficient is taken from the final sum.
                                n1           <= 3'd0;
                                state        <= DONE;
                                pix_ready_q  <= 1'b0;
                                coef_valid_q <= 1'b1;
                                coef_data_q  <= sat_value;
                            end else begin
                                n1 <= n1 + 3'd1;
                            end
                        end else begin
                            n2 <= n2 + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (coef_fire) begin
                        acc          <= '0;
                        state        <= ACCUM;
                        pix_ready_q  <= 1'b1;
                        coef_valid_q <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_dct_coeff_accum.sv
// tb/tb_dct_coeff_accum.sv - directed scoreboard bench for dct_coeff_accum
module tb_dct_coeff_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   lut_mode = 0;
    int   errors = 0;
    int   checks = 0;
    logic signed [15:0] sb[$];

    dct_coeff_accum_if #(.OUT_W(16)) bus ();

    dct_coeff_accum #(.ACC_W(48), .FRAC_BITS(8), .OUT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Q8 cosine table for k1=7, k2=4: row magnitude, row sign alternates, column sign +--++--+.
    function automatic logic signed [31:0] lut_tab(input logic [2:0] r, input logic [2:0] c);
        int mag;
        int v;
        case (r)
            3'd0, 3'd7: mag = 35;
            3'd1, 3'd6: mag = 100;
            3'd2, 3'd5: mag = 150;
            default:    mag = 177;
        endcase
        v = mag;
        if (r[0]) v = -v;
        if (c[0] ^ c[1]) v = -v;
        return 32'(v);
    endfunction

    always_comb begin
        bus.lut_cos = (lut_mode == 1) ? 32'sh7FFF_FFFF : lut_tab(bus.lut_n1, bus.lut_n2);
    end

    function automatic logic [7:0] pix_for(input int pmode, input int idx);
        logic [2:0] r;
        logic [2:0] c;
        r = 3'(idx / 8);
        c = 3'(idx % 8);
        case (pmode)
            0: return 8'd128;
            1: return (lut_tab(r, c) > 0) ? 8'd255 : 8'd0;
            2: return 8'd255;
            default: return 8'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [47:0] obs, input logic signed [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic send_block(input int pmode, input int gap, input int npix);
        int cnt = 0;
        int cyc = 0;
        while (cnt < npix) begin
            @(negedge clk);
            cyc++;
            if (cyc > 2000) begin
                chk("send_timeout", 48'(cnt), 48'(npix));
                break;
            end
            if (gap != 0 && $urandom_range(1, 0) == 0) begin
                bus.pix_valid = 1'b0;
            end else begin
                bus.pix_valid = 1'b1;
                bus.pix_data  = pix_for(pmode, cnt);
            end
            chk("lut_n1", 48'(bus.lut_n1), 48'(cnt / 8));
            chk("lut_n2", 48'(bus.lut_n2), 48'(cnt % 8));
            chk("pix_ready_accum", 48'(bus.pix_ready), 48'd1);
            if (bus.pix_valid && bus.pix_ready) cnt++;
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk("coef_valid_latency", 48'(bus.coef_valid), (npix == 64) ? 48'd1 : 48'd0);
    endtask

    task automatic get_coef(input int hold);
        int t = 0;
        logic signed [15:0] exp;
        while (!bus.coef_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("coef_valid_seen", 48'(bus.coef_valid), 48'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 48'(sb.size()), 48'd1);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        chk("coef_data", bus.coef_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_coef_valid", 48'(bus.coef_valid), 48'd1);
            chk("hold_coef_data", bus.coef_data, exp);
            chk("hold_pix_ready", 48'(bus.pix_ready), 48'd0);
        end
        bus.coef_ready = 1'b1;
        @(negedge clk);
        bus.coef_ready = 1'b0;
        chk("coef_valid_after_accept", 48'(bus.coef_valid), 48'd0);
        chk("pix_ready_after_accept", 48'(bus.pix_ready), 48'd1);
    endtask

    initial begin
        bus.pix_valid  = 1'b0;
        bus.pix_data   = 8'd0;
        bus.coef_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pix_ready", 48'(bus.pix_ready), 48'd1);
        chk("rst_coef_valid", 48'(bus.coef_valid), 48'd0);
        chk("rst_coef_data", bus.coef_data, 48'sd0);
        chk("rst_lut_n1", 48'(bus.lut_n1), 48'd0);
        chk("rst_lut_n2", 48'(bus.lut_n2), 48'd0);

        lut_mode = 0;
        sb.push_back(16'sd0);
        send_block(0, 0, 64);
        get_coef(0);

        sb.push_back(16'sd3681);
        send_block(1, 0, 64);
        get_coef(0);

        lut_mode = 1;
        sb.push_back(16'sd32767);
        send_block(2, 0, 64);
        get_coef(0);
        sb.push_back(-16'sd32768);
        send_block(3, 0, 64);
        get_coef(0);

        lut_mode = 0;
        sb.push_back(16'sd3681);
        send_block(1, 0, 64);
        get_coef(5);
        sb.push_back(16'sd3681);
        send_block(1, 0, 64);
        get_coef(0);

        sb.push_back(16'sd3681);
        send_block(1, 1, 64);
        get_coef(2);

        send_block(1, 0, 30);
        rst_n = 1'b0;
        #1;
        chk("async_rst_lut_n1", 48'(bus.lut_n1), 48'd0);
        chk("async_rst_coef_valid", 48'(bus.coef_valid), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_lut_n2", 48'(bus.lut_n2), 48'd0);
        sb.push_back(16'sd3681);
        send_block(1, 0, 64);
        get_coef(0);

        send_block(1, 0, 30);
        flush = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'd255;
        @(negedge clk);
        flush = 1'b0;
        bus.pix_valid = 1'b0;
        chk("flush_lut_n1", 48'(bus.lut_n1), 48'd0);
        chk("flush_lut_n2", 48'(bus.lut_n2), 48'd0);
        chk("flush_coef_valid", 48'(bus.coef_valid), 48'd0);
        sb.push_back(16'sd3681);
        send_block(1, 0, 64);
        get_coef(0);

        send_block(1, 0, 64);
        flush = 1'b1;
        bus.coef_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.coef_ready = 1'b0;
        chk("flush_done_coef_valid", 48'(bus.coef_valid), 48'd0);
        chk("flush_done_pix_ready", 48'(bus.pix_ready), 48'd1);
        sb.push_back(16'sd0);
        send_block(0, 0, 64);
        get_coef(0);

        chk("scoreboard_drained", 48'(sb.size()), 48'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
